// File: rtl/truth_table_checker.sv
// truth_table_checker: checks observed two-input gate samples against the EXPECT truth table.
// Define TRUTH_TABLE_CHECKER_FIRST_FAIL_EN to add first_fail_valid/first_fail_vec capture.
module truth_table_checker #(
    parameter logic [3:0] EXPECT = 4'b1101,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_x,
    input  logic             in_y,
    input  logic             in_s,
    output logic             mismatch,
    output logic [3:0]       seen,
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec,
`endif
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic             done,
    output logic             pass
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t           state_q, state_d;
    logic [3:0]       seen_q, seen_d;
    logic [CNT_W-1:0] scnt_q, scnt_d, ecnt_q, ecnt_d;
    logic             mis_q, mis_d;
    logic             acc, fail;
    logic [1:0]       idx;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    logic             ffv_q, ffv_d;
    logic [2:0]       ffvec_q, ffvec_d;
`endif
    assign in_ready     = (state_q == RUN) && !start;
    assign mismatch     = mis_q;
    assign seen         = seen_q;
    assign sample_count = scnt_q;
    assign err_count    = ecnt_q;
    assign done         = state_q == DONE;
    assign pass         = done && (ecnt_q == '0);
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
`endif
    always_comb begin
        idx     = {in_x, in_y};
        acc     = in_valid && in_ready;
        fail    = in_s != EXPECT[idx];
        state_d = state_q;
        seen_d  = seen_q;
        scnt_d  = scnt_q;
        ecnt_d  = ecnt_q;
        mis_d   = 1'b0;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
`endif
        if (start) begin
            state_d = RUN;
            seen_d  = '0;
            scnt_d  = '0;
            ecnt_d  = '0;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
            ffv_d   = 1'b0;
            ffvec_d = '0;
`endif
        end else if (acc) begin
            seen_d = seen_q | (4'b0001 << idx);
            scnt_d = (scnt_q == MAX) ? scnt_q : scnt_q + CNT_W'(1);
            if (fail) begin
                ecnt_d = (ecnt_q == MAX) ? ecnt_q : ecnt_q + CNT_W'(1);
                mis_d  = 1'b1;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
                if (!ffv_q) begin
                    ffv_d   = 1'b1;
                    ffvec_d = {in_x, in_y, in_s};
                end
`endif
            end
            if (seen_d == 4'b1111) state_d = DONE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seen_q  <= '0;
            scnt_q  <= '0;
            ecnt_q  <= '0;
            mis_q   <= 1'b0;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            scnt_q  <= scnt_d;
            ecnt_q  <= ecnt_d;
            mis_q   <= mis_d;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
`endif
        end
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed vector table, saturation/reset sequences and a randomized
// reference-model run for truth_table_checker (wide and CNT_W=2 instances share stimulus).
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic rst_n, start, in_valid, in_x, in_y, in_s;
    logic rdy, mis, dn, ps, rdy2, mis2, dn2, ps2;
    logic [3:0] seen, seen2;
    logic [7:0] sc, ec;
    logic [1:0] sc2, ec2;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    logic ffv, ffv2;
    logic [2:0] ffvec, ffvec2;
`endif
    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    truth_table_checker u_dut (
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
        .first_fail_valid(ffv), .first_fail_vec(ffvec),
`endif
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy),
        .in_x(in_x), .in_y(in_y), .in_s(in_s), .mismatch(mis), .seen(seen),
        .sample_count(sc), .err_count(ec), .done(dn), .pass(ps));

    truth_table_checker #(.CNT_W(2)) u_sat (
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2),
`endif
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy2),
        .in_x(in_x), .in_y(in_y), .in_s(in_s), .mismatch(mis2), .seen(seen2),
        .sample_count(sc2), .err_count(ec2), .done(dn2), .pass(ps2));

    typedef struct {
        logic st, v, x, y, s, rdy;
        logic [3:0] seen;
        int sc, ec;
        logic mis, dn, ps;
    } vec_t;

    function automatic vec_t mk(logic st, v, x, y, s, rdy, logic [3:0] sn, int c, e, logic m, d, p);
        vec_t r;
        r.st = st; r.v = v; r.x = x; r.y = y; r.s = s; r.rdy = rdy;
        r.seen = sn; r.sc = c; r.ec = e; r.mis = m; r.dn = d; r.ps = p;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, v, x, y, s);
        @(negedge clk);
        start = st; in_valid = v; in_x = x; in_y = y; in_s = s;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rdy"}, 32'(rdy), 0);
        chk({nm, "_seen"}, 32'(seen), 0);
        chk({nm, "_sc"}, 32'(sc), 0);
        chk({nm, "_ec"}, 32'(ec), 0);
        chk({nm, "_mis"}, 32'(mis), 0);
        chk({nm, "_done"}, 32'(dn), 0);
        chk({nm, "_pass"}, 32'(ps), 0);
        chk({nm, "_sat_sc"}, 32'(sc2), 0);
    endtask

    function automatic int sat(int v, int mx);
        return v > mx ? mx : v;
    endfunction

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; start = 0; in_valid = 0; in_x = 0; in_y = 0; in_s = 0;
        // Directed rows: expected values follow EXPECT = s = x | ~y
        tbl.push_back(mk(1,0,0,0,0, 0, 4'b0000,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1, 4'b0001,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0,1,0, 1, 4'b0011,2,0, 0,0,0));
        tbl.push_back(mk(0,1,1,0,1, 1, 4'b0111,3,0, 0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1, 4'b1111,4,0, 0,1,1));
        tbl.push_back(mk(0,1,0,0,0, 0, 4'b1111,4,0, 0,1,1));
        tbl.push_back(mk(1,0,0,0,0, 0, 4'b0000,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1, 4'b0001,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0,1,1, 1, 4'b0011,2,1, 1,0,0));
        tbl.push_back(mk(0,1,1,0,1, 1, 4'b0111,3,1, 0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1, 4'b1111,4,1, 0,1,0));
        tbl.push_back(mk(1,0,0,0,0, 0, 4'b0000,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1, 4'b0001,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1, 4'b0001,2,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1, 4'b0001,3,0, 0,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0, 1, 4'b0001,3,0, 0,0,0));
        tbl.push_back(mk(0,1,0,1,0, 1, 4'b0011,4,0, 0,0,0));
        tbl.push_back(mk(0,1,1,0,1, 1, 4'b0111,5,0, 0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1, 4'b1111,6,0, 0,1,1));
        tbl.push_back(mk(1,0,0,0,0, 0, 4'b0000,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1, 4'b0001,1,0, 0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0, 4'b0000,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1, 4'b0001,1,1, 1,0,0));

        @(posedge clk); #1;
        chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].s);
            #1 chk($sformatf("row%0d_rdy", i), 32'(rdy), 32'(tbl[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("row%0d_seen", i), 32'(seen), 32'(tbl[i].seen));
            chk($sformatf("row%0d_sc", i), 32'(sc), tbl[i].sc);
            chk($sformatf("row%0d_ec", i), 32'(ec), tbl[i].ec);
            chk($sformatf("row%0d_mis", i), 32'(mis), 32'(tbl[i].mis));
            chk($sformatf("row%0d_done", i), 32'(dn), 32'(tbl[i].dn));
            chk($sformatf("row%0d_pass", i), 32'(ps), 32'(tbl[i].ps));
        end

        begin : saturation
            int pulses = 0;
            drive(1,0,0,0,0);
            for (int k = 1; k <= 5; k++) begin
                drive(0,1,0,1,1);
                @(posedge clk); #1;
                if (mis2) pulses++;
                chk("sat_sc", 32'(sc2), sat(k, 3));
                chk("sat_ec", 32'(ec2), sat(k, 3));
                chk("sat_done", 32'(dn2), 0);
            end
            drive(0,0,0,0,0);
            @(posedge clk); #1;
            chk("sat_mis_idle", 32'(mis2), 0);
            chk("sat_pulses", pulses, 5);
        end

        drive(1,0,0,0,0);
        drive(0,1,0,0,1);
        drive(0,1,0,1,1);
        @(posedge clk); #1;
        chk("pre_reset_mis", 32'(mis), 1);
        chk("pre_reset_sc", 32'(sc), 2);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk); rst_n = 1'b1;
        drive(0,1,0,0,1);
        #1 chk("post_reset_rdy", 32'(rdy), 0);
        @(posedge clk); #1;
        chk("post_reset_sc", 32'(sc), 0);

        begin : random_run
            bit run_m = 0, done_m = 0, mis_m = 0;
            bit cov[4];
            int ns = 0, ne = 0;
            logic st, v, x, y, s, acc, good;
            logic [3:0] cov_v;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
            bit ffv_m = 0;
            logic [2:0] ffvec_m = '0;
`endif
            for (int i = 0; i < 2000; i++) begin
                st = (i == 0) || ($urandom_range(0, 19) == 0);
                v = $urandom_range(0, 3) != 0;
                x = 1'($urandom_range(0, 1));
                y = 1'($urandom_range(0, 1));
                good = x | ~y;
                s = ($urandom_range(0, 3) == 0) ? ~good : good;
                drive(st, v, x, y, s);
                #1 chk("rnd_rdy", 32'(rdy), 32'(run_m && !st));
                acc = v && run_m && !st;
                @(posedge clk);
                mis_m = 0;
                if (st) begin
                    run_m = 1; done_m = 0; ns = 0; ne = 0;
                    foreach (cov[j]) cov[j] = 0;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
                    ffv_m = 0; ffvec_m = '0;
`endif
                end else if (acc) begin
                    cov[x * 2 + y] = 1;
                    ns++;
                    if (s != good) begin
                        ne++; mis_m = 1;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
                        if (!ffv_m) begin ffv_m = 1; ffvec_m = {x, y, s}; end
`endif
                    end
                    if (cov[0] && cov[1] && cov[2] && cov[3]) begin run_m = 0; done_m = 1; end
                end
                for (int j = 0; j < 4; j++) cov_v[j] = cov[j];
                #1;
                chk("rnd_seen", 32'(seen), 32'(cov_v));
                chk("rnd_sc", 32'(sc), sat(ns, 255));
                chk("rnd_ec", 32'(ec), sat(ne, 255));
                chk("rnd_mis", 32'(mis), 32'(mis_m));
                chk("rnd_done", 32'(dn), 32'(done_m));
                chk("rnd_pass", 32'(ps), 32'(done_m && ne == 0));
                chk("rnd_sat_sc", 32'(sc2), sat(ns, 3));
                chk("rnd_sat_ec", 32'(ec2), sat(ne, 3));
                chk("rnd_sat_done", 32'(dn2), 32'(done_m));
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
                chk("rnd_ffv", 32'(ffv), 32'(ffv_m));
                chk("rnd_ffvec", 32'(ffvec), 32'(ffvec_m));
`endif
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
